pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register with a valid/ready handshake (upstream allow-in, downstream ready). It is the parametrised successor of the per-stage hand-written registers, such as decode to execute.
- The payload is a single packed vector of width DATA_W. Stage-specific fields are packed into it at the instantiation site.
- It adds a synchronous flush, a configurable NOP payload for bubbles, and an optional 2-entry skid mode. In skid mode, upstream ready is registered, which breaks the combinational ready chain between stages.

Parameters:
- DATA_W, 32, payload width in bits, legal range 1..1024.
- SKID, 0, 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered ready.
- NOP_VALUE, {DATA_W{1'b0}}, payload driven whenever an entry is empty, flushed or reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous kill of all held beats.
- up_valid_i  in  1  upstream beat valid.
- up_ready_o  out  1  stage can accept a beat (allow-in).
- up_data_i  in  DATA_W  upstream payload.
- dn_valid_o  out  1  output beat valid.
- dn_ready_i  in  1  downstream allow-in.
- dn_data_o  out  DATA_W  output payload.
- count_o  out  2  occupied entries: 0..1 when SKID=0, 0..2 when SKID=1.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst is synchronous and active-high.
- Handshake definitions:
  - up_fire = up_valid_i & up_ready_o.
  - dn_fire = dn_valid_o & dn_ready_i.
- Reset values (rst=1 at a clock edge), applied to both entries:
  - dn_valid_o = 0
  - dn_data_o = NOP_VALUE
  - count_o = 0
  - up_ready_o = 1
  - skid entry = NOP_VALUE
- Priority order: rst, then flush_i, then handshake updates.
- flush_i=1 at an edge:
  - Every held beat is discarded and all outputs take their reset values.
  - An up_fire in the same cycle is dropped.
  - Any downstream fire in that cycle is still counted as delivered by the consumer.
- Stability rule: while dn_valid_o=1 and dn_ready_i=0, dn_data_o and dn_valid_o hold unchanged, unless rst or flush_i is asserted.
- Latency: 1 cycle from up_fire to dn_valid_o, in both modes. Beats are delivered in order and never duplicated.
- SKID=0:
  - up_ready_o = ~dn_valid_o | dn_ready_i. This path is combinational.
  - On up_fire, the main register takes up_data_i and dn_valid_o becomes 1.
  - On dn_fire without up_fire, the main register takes NOP_VALUE and dn_valid_o becomes 0. This inserts a bubble.
  - count_o = dn_valid_o.
- SKID=1 state machine:
  - States: EMPTY(0), BUSY(1), FULL(2). count_o equals the state code.
  - up_ready_o is registered: it is 1 in EMPTY and BUSY, and 0 in FULL. up_ready_o does not depend combinationally on dn_ready_i.
  - dn_valid_o is 1 in BUSY and FULL.
- SKID=1 transitions:
  - EMPTY, with up_fire: go to BUSY, main <= up_data_i.
  - EMPTY, no up_fire: stay in EMPTY.
  - BUSY, with up_fire and dn_fire: stay in BUSY, main <= up_data_i.
  - BUSY, with up_fire and no dn_fire: go to FULL, skid <= up_data_i, main held.
  - BUSY, with dn_fire and no up_fire: go to EMPTY, main <= NOP_VALUE.
  - FULL, with dn_fire: go to BUSY, main <= skid, skid <= NOP_VALUE.
  - FULL, no dn_fire: hold. up_fire cannot occur in FULL.
- Illegal state encoding (3): treated as EMPTY on the next edge, with both entries set to NOP_VALUE.
- Throughput: 1 beat per cycle sustained in both modes while dn_ready_i=1.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams PIPE_EMPTY=2'd0, PIPE_BUSY=2'd1, PIPE_FULL=2'd2.
  - the typedef for the 2-bit occupancy state.
- One sub-module, pipe_data_reg:
  - a DATA_W register with load enable, load value and synchronous clear to NOP_VALUE.
  - instantiated once for main and once for skid, the skid instance only under SKID=1.
- Mode selection is done with a generate on SKID. There are no other sub-modules.

Test Plan:
- Reset, SKID=1: hold rst high for 2 cycles with up_valid_i=1 and up_data_i=0xDEAD -> dn_valid_o=0, dn_data_o=NOP_VALUE, count_o=0, up_ready_o=1 on the first cycle after release.
- Streaming, both modes: send 0x11,0x22,0x33 on consecutive cycles with dn_ready_i=1 -> dn_data_o shows 0x11,0x22,0x33 on cycles 1,2,3; count_o stays 1; the cycle after that gives dn_valid_o=0 and dn_data_o=NOP_VALUE.
- Backpressure, SKID=1: drive dn_ready_i=0 and send 0xA1,0xA2 -> count_o=2 and up_ready_o=0 from the next cycle; dn_data_o holds 0xA1. Then raise dn_ready_i -> 0xA1 then 0xA2 are delivered, count_o goes 2,1,0, and up_ready_o returns to 1 one cycle after the first dn_fire.
- Backpressure, SKID=0: hold dn_valid_o=1 and dn_ready_i=0, then drive up_valid_i=1 -> up_ready_o=0 in the same cycle. Raise dn_ready_i in the same cycle -> up_ready_o=1 combinationally and the new beat is captured.
- Flush while FULL, SKID=1: with entries 0xB1,0xB2 held, assert flush_i together with up_valid_i=1 carrying 0xB3 -> the next cycle shows count_o=0, dn_valid_o=0, dn_data_o=NOP_VALUE; 0xB3 is never delivered.
- Random soak: DATA_W=64, random valid/ready/flush over 10k cycles against a queue scoreboard -> no loss, no duplication, in-order delivery, no change in dn_data_o while stalled, count_o matches the model.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register.
//   PIPE_EMPTY / PIPE_BUSY / PIPE_FULL : occupancy codes, equal to count_o
//   pipe_state_t                       : 2-bit occupancy state of the skid FSM
package pipe_pkg;

   localparam logic [1:0] PIPE_EMPTY = 2'd0;
   localparam logic [1:0] PIPE_BUSY  = 2'd1;
   localparam logic [1:0] PIPE_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY   = PIPE_EMPTY,
      ST_BUSY    = PIPE_BUSY,
      ST_FULL    = PIPE_FULL,
      ST_ILLEGAL = 2'd3
   } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear to NOP_VALUE.
//   clk_i  : clock, rising edge
//   clr    : synchronous clear to NOP_VALUE (wins over ld)
//   ld     : load enable
//   ld_val : value loaded when ld=1
//   q      : registered payload
module pipe_data_reg #(
   parameter int                 DATA_W    = 32,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
   input  logic              clk_i,
   input  logic              clr,
   input  logic              ld,
   input  logic [DATA_W-1:0] ld_val,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk_i) begin
      if (clr) begin
         q <= NOP_VALUE;
      end else if (ld) begin
         q <= ld_val;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// SKID=0: one entry, combinational up_ready_o. SKID=1: two entries with
// up_ready_o decoded straight from the state flops, so no combinational
// path from dn_ready_i to up_ready_o.
//   clk_i, rst            : clock, synchronous active-high reset
//   flush_i               : kill all held beats (same-cycle up beat dropped)
//   up_valid_i/up_ready_o : upstream handshake, up_data_i payload
//   dn_valid_o/dn_ready_i : downstream handshake, dn_data_o payload
//   count_o               : occupied entries
//
// Skid FSM (SKID=1):
//   state      | meaning
//   ST_EMPTY   | no beat held, ready to accept
//   ST_BUSY    | main holds the output beat, ready to accept
//   ST_FULL    | main + skid both hold beats, not ready
//   ST_ILLEGAL | unreachable; recovers to ST_EMPTY clearing both entries
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W    = 32,
   parameter int                 SKID      = 0,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o,
   output logic [1:0]        count_o
);

   logic              up_fire;
   logic              dn_fire;
   logic              main_clr;
   logic              main_ld;
   logic [DATA_W-1:0] main_val;
   logic [DATA_W-1:0] main_q;

   assign up_fire   = up_valid_i & up_ready_o;
   assign dn_fire   = dn_valid_o & dn_ready_i;
   assign dn_data_o = main_q;

   pipe_data_reg #(
      .DATA_W    (DATA_W),
      .NOP_VALUE (NOP_VALUE)
   ) u_main (
      .clk_i  (clk_i),
      .clr    (main_clr),
      .ld     (main_ld),
      .ld_val (main_val),
      .q      (main_q)
   );

   generate
      if (SKID == 0) begin : g_single
         logic valid_q;

         always_ff @(posedge clk_i) begin
            if (rst || flush_i) begin
               valid_q <= 1'b0;
            end else if (up_fire) begin
               valid_q <= 1'b1;
            end else if (dn_fire) begin
               valid_q <= 1'b0;
            end
         end

         assign up_ready_o = ~valid_q | dn_ready_i;
         assign dn_valid_o = valid_q;
         assign count_o    = {1'b0, valid_q};

         // a drained register reloads NOP so bubbles carry a harmless payload
         assign main_clr = rst | flush_i;
         assign main_ld  = up_fire | dn_fire;
         assign main_val = up_fire ? up_data_i : NOP_VALUE;
      end else begin : g_skid
         pipe_state_t       state_q;
         pipe_state_t       state_d;
         logic              skid_clr;
         logic              skid_ld;
         logic [DATA_W-1:0] skid_val;
         logic [DATA_W-1:0] skid_q;

         always_ff @(posedge clk_i) begin
            if (rst || flush_i) begin
               state_q <= ST_EMPTY;
            end else begin
               state_q <= state_d;
            end
         end

         always_comb begin
            state_d  = state_q;
            main_clr = rst | flush_i;
            skid_clr = rst | flush_i;
            main_ld  = 1'b0;
            main_val = up_data_i;
            skid_ld  = 1'b0;
            skid_val = up_data_i;
            case (state_q)
               ST_EMPTY: begin
                  if (up_fire) begin
                     state_d = ST_BUSY;
                     main_ld = 1'b1;
                  end
               end
               ST_BUSY: begin
                  if (up_fire && dn_fire) begin
                     main_ld = 1'b1;
                  end else if (up_fire) begin
                     state_d = ST_FULL;
                     skid_ld = 1'b1;
                  end else if (dn_fire) begin
                     state_d  = ST_EMPTY;
                     main_ld  = 1'b1;
                     main_val = NOP_VALUE;
                  end
               end
               ST_FULL: begin
                  if (dn_fire) begin
                     state_d  = ST_BUSY;
                     main_ld  = 1'b1;
                     main_val = skid_q;
                     skid_ld  = 1'b1;
                     skid_val = NOP_VALUE;
                  end
               end
               default: begin
                  state_d  = ST_EMPTY;
                  main_clr = 1'b1;
                  skid_clr = 1'b1;
               end
            endcase
         end

         assign up_ready_o = (state_q == ST_EMPTY) | (state_q == ST_BUSY);
         assign dn_valid_o = (state_q == ST_BUSY)  | (state_q == ST_FULL);
         assign count_o    = state_q;

         pipe_data_reg #(
            .DATA_W    (DATA_W),
            .NOP_VALUE (NOP_VALUE)
         ) u_skid (
            .clk_i  (clk_i),
            .clr    (skid_clr),
            .ld     (skid_ld),
            .ld_val (skid_val),
            .q      (skid_q)
         );
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks on 32-bit SKID=1 / SKID=0 stages, then a random soak
// on 64-bit instances of both modes against queue scoreboards.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP32 = 32'h0000_0013;
   localparam logic [63:0] NOP64 = 64'hA5A5_0000_0000_0013;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // instance a: SKID=1, 32 bit
   logic        a_rst, a_flush, a_up_valid, a_up_ready, a_dn_valid, a_dn_ready;
   logic [31:0] a_up_data, a_dn_data;
   logic [1:0]  a_count;
   // instance b: SKID=0, 32 bit
   logic        b_rst, b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
   logic [31:0] b_up_data, b_dn_data;
   logic [1:0]  b_count;
   // soak instances share inputs
   logic        k_rst, k_flush, k_up_valid, k_dn_ready;
   logic [63:0] k_up_data;
   logic        k1_up_ready, k1_dn_valid, k0_up_ready, k0_dn_valid;
   logic [63:0] k1_dn_data, k0_dn_data;
   logic [1:0]  k1_count, k0_count;

   pipe_stage_reg #(.DATA_W(32), .SKID(1), .NOP_VALUE(NOP32)) u_a (
      .clk_i(clk_i), .rst(a_rst), .flush_i(a_flush),
      .up_valid_i(a_up_valid), .up_ready_o(a_up_ready), .up_data_i(a_up_data),
      .dn_valid_o(a_dn_valid), .dn_ready_i(a_dn_ready), .dn_data_o(a_dn_data),
      .count_o(a_count));

   pipe_stage_reg #(.DATA_W(32), .SKID(0), .NOP_VALUE(NOP32)) u_b (
      .clk_i(clk_i), .rst(b_rst), .flush_i(b_flush),
      .up_valid_i(b_up_valid), .up_ready_o(b_up_ready), .up_data_i(b_up_data),
      .dn_valid_o(b_dn_valid), .dn_ready_i(b_dn_ready), .dn_data_o(b_dn_data),
      .count_o(b_count));

   pipe_stage_reg #(.DATA_W(64), .SKID(1), .NOP_VALUE(NOP64)) u_k1 (
      .clk_i(clk_i), .rst(k_rst), .flush_i(k_flush),
      .up_valid_i(k_up_valid), .up_ready_o(k1_up_ready), .up_data_i(k_up_data),
      .dn_valid_o(k1_dn_valid), .dn_ready_i(k_dn_ready), .dn_data_o(k1_dn_data),
      .count_o(k1_count));

   pipe_stage_reg #(.DATA_W(64), .SKID(0), .NOP_VALUE(NOP64)) u_k0 (
      .clk_i(clk_i), .rst(k_rst), .flush_i(k_flush),
      .up_valid_i(k_up_valid), .up_ready_o(k0_up_ready), .up_data_i(k_up_data),
      .dn_valid_o(k0_dn_valid), .dn_ready_i(k_dn_ready), .dn_data_o(k0_dn_data),
      .count_o(k0_count));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   logic [31:0] stream_v [3] = '{32'h11, 32'h22, 32'h33};
   logic [63:0] q1 [$];
   logic [63:0] q0 [$];
   logic        f1u, f1d, f0u, f0d;

   initial begin
      a_rst = 1; a_flush = 0; a_up_valid = 1; a_up_data = 32'hDEAD; a_dn_ready = 0;
      b_rst = 1; b_flush = 0; b_up_valid = 1; b_up_data = 32'hDEAD; b_dn_ready = 0;
      k_rst = 1; k_flush = 0; k_up_valid = 0; k_up_data = '0;       k_dn_ready = 0;
      step();
      step();
      a_rst = 0; a_up_valid = 0;
      b_rst = 0; b_up_valid = 0;
      chk("a_rst_valid", a_dn_valid, 0);
      chk("a_rst_data",  a_dn_data,  NOP32);
      chk("a_rst_count", a_count,    0);
      chk("a_rst_ready", a_up_ready, 1);
      chk("b_rst_valid", b_dn_valid, 0);
      chk("b_rst_data",  b_dn_data,  NOP32);
      chk("b_rst_count", b_count,    0);
      chk("b_rst_ready", b_up_ready, 1);
      step();
      chk("a_rst_hold_valid", a_dn_valid, 0);

      // streaming, both modes in lockstep
      a_dn_ready = 1; b_dn_ready = 1;
      for (int i = 0; i < 3; i++) begin
         a_up_valid = 1; a_up_data = stream_v[i];
         b_up_valid = 1; b_up_data = stream_v[i];
         step();
         chk("a_str_data",  a_dn_data,  stream_v[i]);
         chk("a_str_count", a_count,    1);
         chk("b_str_data",  b_dn_data,  stream_v[i]);
         chk("b_str_valid", b_dn_valid, 1);
      end
      a_up_valid = 0; b_up_valid = 0;
      step();
      chk("a_str_end_valid", a_dn_valid, 0);
      chk("a_str_end_data",  a_dn_data,  NOP32);
      chk("a_str_end_count", a_count,    0);
      chk("b_str_end_valid", b_dn_valid, 0);
      chk("b_str_end_data",  b_dn_data,  NOP32);

      // SKID=1 backpressure
      a_dn_ready = 0; a_up_valid = 1; a_up_data = 32'hA1;
      step();
      chk("a_bp_count1", a_count,    1);
      chk("a_bp_ready1", a_up_ready, 1);
      a_up_data = 32'hA2;
      step();
      chk("a_bp_count2", a_count,    2);
      chk("a_bp_ready2", a_up_ready, 0);
      chk("a_bp_data2",  a_dn_data,  32'hA1);
      a_up_valid = 0;
      step();
      chk("a_bp_hold_data",  a_dn_data, 32'hA1);
      chk("a_bp_hold_count", a_count,   2);
      a_dn_ready = 1;
      step();
      chk("a_bp_dq1_data",  a_dn_data,  32'hA2);
      chk("a_bp_dq1_count", a_count,    1);
      chk("a_bp_dq1_ready", a_up_ready, 1);
      step();
      chk("a_bp_dq2_count", a_count,    0);
      chk("a_bp_dq2_valid", a_dn_valid, 0);
      chk("a_bp_dq2_data",  a_dn_data,  NOP32);

      // SKID=1 flush while full, same-cycle beat dropped
      a_dn_ready = 0; a_up_valid = 1; a_up_data = 32'hB1;
      step();
      a_up_data = 32'hB2;
      step();
      chk("a_fl_pre_count", a_count, 2);
      a_flush = 1; a_up_data = 32'hB3;
      step();
      a_flush = 0; a_up_valid = 0; a_dn_ready = 1;
      chk("a_fl_count", a_count,    0);
      chk("a_fl_valid", a_dn_valid, 0);
      chk("a_fl_data",  a_dn_data,  NOP32);
      chk("a_fl_ready", a_up_ready, 1);
      step();
      chk("a_fl_nob3_valid", a_dn_valid, 0);

      // SKID=1 flush while busy with an accepted up beat
      a_up_valid = 1; a_up_data = 32'hC1;
      step();
      a_flush = 1; a_up_data = 32'hC2;
      step();
      a_flush = 0; a_up_valid = 0;
      chk("a_flb_count", a_count, 0);
      step();
      chk("a_flb_valid", a_dn_valid, 0);

      // SKID=0 backpressure with combinational ready
      b_dn_ready = 0; b_up_valid = 1; b_up_data = 32'h44;
      step();
      chk("b_bp_data1", b_dn_data, 32'h44);
      b_up_data = 32'h55;
      #1;
      chk("b_bp_ready_lo", b_up_ready, 0);
      step();
      chk("b_bp_hold_data",  b_dn_data,  32'h44);
      chk("b_bp_hold_count", b_count,    1);
      b_dn_ready = 1;
      #1;
      chk("b_bp_ready_hi", b_up_ready, 1);
      step();
      chk("b_bp_cap_data",  b_dn_data,  32'h55);
      chk("b_bp_cap_valid", b_dn_valid, 1);
      b_up_valid = 0;
      step();
      chk("b_bp_drain_valid", b_dn_valid, 0);
      chk("b_bp_drain_data",  b_dn_data,  NOP32);

      // SKID=0 flush drops the same-cycle up beat
      b_dn_ready = 0; b_up_valid = 1; b_up_data = 32'h66;
      step();
      b_dn_ready = 1; b_flush = 1; b_up_data = 32'h77;
      step();
      b_flush = 0; b_up_valid = 0;
      chk("b_fl_valid", b_dn_valid, 0);
      chk("b_fl_data",  b_dn_data,  NOP32);
      chk("b_fl_count", b_count,    0);
      step();
      chk("b_fl_no77_valid", b_dn_valid, 0);

      // random soak, both modes
      k_rst = 0;
      for (int c = 0; c < 10000; c++) begin
         k_up_valid = ($urandom_range(0, 3) != 0);
         k_dn_ready = ($urandom_range(0, 3) != 0);
         k_flush    = ($urandom_range(0, 63) == 0);
         k_up_data  = {$urandom, $urandom};
         #1;
         chk("k1_ready", k1_up_ready, q1.size() < 2);
         chk("k0_ready", k0_up_ready, (q0.size() == 0) | k_dn_ready);
         f1u = k_up_valid & k1_up_ready;
         f1d = k1_dn_valid & k_dn_ready;
         f0u = k_up_valid & k0_up_ready;
         f0d = k0_dn_valid & k_dn_ready;
         @(posedge clk_i);
         #1;
         if (f1d && q1.size() > 0) void'(q1.pop_front());
         if (f0d && q0.size() > 0) void'(q0.pop_front());
         if (k_flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (f1u) q1.push_back(k_up_data);
            if (f0u) q0.push_back(k_up_data);
         end
         chk("k1_count", k1_count,    q1.size());
         chk("k1_valid", k1_dn_valid, q1.size() != 0);
         chk("k1_data",  k1_dn_data,  (q1.size() != 0) ? q1[0] : NOP64);
         chk("k0_count", k0_count,    q0.size());
         chk("k0_valid", k0_dn_valid, q0.size() != 0);
         chk("k0_data",  k0_dn_data,  (q0.size() != 0) ? q0[0] : NOP64);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
